// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/gnt/rvalid
// handshake, presents one instruction at a time and traps on response timeout.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_W   = 8,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        inst_ack,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        imem_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DROP  = 3'd4,
    HALT  = 3'd5
  } state_t;

  // Counter value seen during the last permitted wait cycle.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_t              state_r, state_s;
  logic [31:0]         pc_r, pc_s;
  logic [31:0]         inst_r, inst_s;
  logic [WAIT_W-1:0]   cnt_r, cnt_s;
  logic                err_r, err_s;
  logic                req_r, valid_r;

  // Next-state, PC, instruction, timeout counter and error decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    inst_s  = inst_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        state_s = REQ;
        if (flush) begin
          pc_s = flush_pc;
        end else begin
          pc_s = pc_r;
        end
      end
      REQ: begin
        if (flush) begin
          pc_s = flush_pc;
          if (imem_gnt) begin
            state_s = DROP;
            cnt_s   = {WAIT_W{1'b0}};
          end else begin
            state_s = REQ;
          end
        end else if (imem_gnt) begin
          state_s = WAIT;
          cnt_s   = {WAIT_W{1'b0}};
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            pc_s    = flush_pc;
            state_s = REQ;
          end else begin
            inst_s  = imem_rdata;
            state_s = VALID;
          end
        end else if (flush) begin
          // The granted request is still in flight; its response must be dropped.
          pc_s    = flush_pc;
          state_s = DROP;
          cnt_s   = {WAIT_W{1'b0}};
        end else if (cnt_r == LAST_WAIT) begin
          err_s   = 1'b1;
          state_s = HALT;
        end else begin
          cnt_s = cnt_r + WAIT_W'(1);
        end
      end
      VALID: begin
        if (flush) begin
          pc_s    = flush_pc;
          state_s = REQ;
        end else if (inst_ack) begin
          pc_s    = npc;
          state_s = REQ;
        end else begin
          state_s = VALID;
        end
      end
      DROP: begin
        if (flush) begin
          pc_s = flush_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rvalid) begin
          state_s = REQ;
        end else if (cnt_r == LAST_WAIT) begin
          err_s   = 1'b1;
          state_s = HALT;
        end else begin
          cnt_s = cnt_r + WAIT_W'(1);
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are flopped from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      inst_r  <= 32'h0000_0000;
      cnt_r   <= {WAIT_W{1'b0}};
      err_r   <= 1'b0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      inst_r  <= inst_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      req_r   <= (state_s == REQ);
      valid_r <= (state_s == VALID);
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = {pc_r[31:2], 2'b00};
  assign pc         = pc_r;
  assign inst       = inst_r;
  assign inst_valid = valid_r;
  assign imem_err   = err_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: table-driven sequential fetches with a response
// scoreboard, then hand-written flush, timeout and mid-operation reset cases.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        inst_ack;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        imem_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    int          gd;
    int          rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] npc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .WAIT_W  (8),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .inst_ack   (inst_ack),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .imem_err   (imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Entered with the DUT in REQ; serves one fetch and optionally retires it.
  task automatic do_fetch(input int gd, input int rd, input logic [31:0] data,
                          input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                          input logic [31:0] npc_v, input bit ack);
    exp_t e;
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, exp_addr);
    chk("pc", pc, exp_pc);
    for (int i = 0; i < gd; i++) begin
      imem_gnt = 1'b0;
      step();
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, exp_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("early_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < rd; i++) begin
      step();
      chk("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    sb.push_back('{pc: exp_pc, inst: data});
    step();
    imem_rvalid = 1'b0;
    chk("valid", 32'(inst_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("valid_pc", pc, e.pc);
    end
    if (ack) begin
      inst_ack = 1'b1;
      npc      = npc_v;
      step();
      inst_ack = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{gd: 0, rd: 0, data: 32'h0000_0013, addr: 32'h0000_0000, pc: 32'h0000_0000, npc: 32'h0000_0004};
    vecs[1] = '{gd: 0, rd: 0, data: 32'h0010_0093, addr: 32'h0000_0004, pc: 32'h0000_0004, npc: 32'h0000_0008};
    vecs[2] = '{gd: 2, rd: 0, data: 32'h0020_8113, addr: 32'h0000_0008, pc: 32'h0000_0008, npc: 32'h0000_0040};
    vecs[3] = '{gd: 0, rd: 1, data: 32'h0031_0193, addr: 32'h0000_0040, pc: 32'h0000_0040, npc: 32'h0000_004A};
    vecs[4] = '{gd: 1, rd: 2, data: 32'h0041_8213, addr: 32'h0000_0048, pc: 32'h0000_004A, npc: 32'h0000_0010};

    rst = 1'b0; npc = 32'h0; inst_ack = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", 32'(imem_err), 32'd0);

    // Boot: release reset, then sequential, stalled, branch and misaligned-pc fetches.
    rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i].gd, vecs[i].rd, vecs[i].data, vecs[i].addr, vecs[i].pc, vecs[i].npc, 1'b1);
    end

    // Flush while waiting: the in-flight response is dropped.
    chk("a_addr", imem_addr, 32'h0000_0010);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    flush = 1'b1; flush_pc = 32'h0000_0100;
    step();
    flush = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd0);
    chk("drop_pc", pc, 32'h0000_0100);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_DEAD;
    step();
    imem_rvalid = 1'b0;
    chk("drop_novalid", 32'(inst_valid), 32'd0);
    do_fetch(0, 0, 32'h0000_0513, 32'h0000_0100, 32'h0000_0100, 32'h0, 1'b0);
    step();
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_inst", inst, 32'h0000_0513);
    chk("hold_pc", pc, 32'h0000_0100);

    // Flush and ack together in VALID: flush target wins.
    flush = 1'b1; inst_ack = 1'b1; flush_pc = 32'h0000_0200; npc = 32'h0000_0014;
    step();
    flush = 1'b0; inst_ack = 1'b0;
    chk("fa_pc", pc, 32'h0000_0200);
    chk("fa_valid", 32'(inst_valid), 32'd0);
    chk("fa_req", 32'(imem_req), 32'd1);
    chk("fa_addr", imem_addr, 32'h0000_0200);

    // Flush in REQ without gnt, stray rvalid ignored; then flush with gnt.
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; flush = 1'b1; flush_pc = 32'h0000_0300;
    step();
    imem_rvalid = 1'b0; flush = 1'b0;
    chk("fr_req", 32'(imem_req), 32'd1);
    chk("fr_addr", imem_addr, 32'h0000_0300);
    chk("fr_valid", 32'(inst_valid), 32'd0);
    imem_gnt = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0304;
    step();
    imem_gnt = 1'b0; flush = 1'b0;
    chk("fg_req", 32'(imem_req), 32'd0);
    chk("fg_pc", pc, 32'h0000_0304);
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    chk("fg_req2", 32'(imem_req), 32'd1);
    chk("fg_addr", imem_addr, 32'h0000_0304);
    chk("fg_valid", 32'(inst_valid), 32'd0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0400;
    step();
    imem_rvalid = 1'b0; flush = 1'b0;
    chk("fw_req", 32'(imem_req), 32'd1);
    chk("fw_addr", imem_addr, 32'h0000_0400);
    chk("fw_valid", 32'(inst_valid), 32'd0);

    // Timeout: no response for MAX_WAIT=4 wait cycles.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("to_err_w1", 32'(imem_err), 32'd0);
    step(); step(); step();
    chk("to_err_w4", 32'(imem_err), 32'd0);
    step();
    chk("to_err", 32'(imem_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    chk("to_valid", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0500;
    step();
    imem_rvalid = 1'b0; flush = 1'b0;
    chk("halt_err", 32'(imem_err), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_pc", pc, 32'h0000_0400);

    // Asynchronous reset in HALT, then fetch resumes from RESET_PC.
    rst = 1'b0;
    #1;
    chk("mr_err", 32'(imem_err), 32'd0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_inst", inst, 32'h0);
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(inst_valid), 32'd0);
    step();
    rst = 1'b1;
    step();
    do_fetch(0, 0, 32'h0000_0093, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch path of the miniRV core. Owns the architectural PC register, issues word fetches to a variable-latency instruction memory over a req/gnt/rvalid handshake, holds the fetched instruction for the core until the core retires it, then loads the next PC from the NPC unit. Supports an asynchronous-to-pipeline redirect (flush), discards stale in-flight responses, and raises a sticky error on memory timeout.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- WAIT_W, 8, width of the response-timeout counter
- MAX_WAIT, 255, cycles in WAIT/DROP before timeout (must fit in WAIT_W bits)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- npc  in  32  next PC from NPC unit for the current instruction
- inst_ack  in  1  core has executed the presented instruction; load npc
- flush  in  1  redirect request; overrides inst_ack
- flush_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, {pc[31:2],2'b00}
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response data
- pc  out  32  PC of the presented/fetching instruction
- inst  out  32  fetched instruction
- inst_valid  out  1  inst/pc valid for execution
- imem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, WAIT, VALID, DROP, HALT.
- Reset (rst=0, immediate): state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, imem_err=0, counter=0.
- IDLE: -> REQ next cycle unconditionally.
- REQ: imem_req=1, imem_addr from pc. gnt -> WAIT. No gnt -> stay REQ; address stable unless flush.
- WAIT: counter increments each cycle. rvalid -> inst<=imem_rdata, -> VALID.
- VALID: inst_valid=1; inst and pc held stable. inst_ack -> pc<=npc, -> REQ.
- Flush (priority over inst_ack and gnt-driven transitions), pc<=flush_pc in all cases:
  - REQ without gnt -> REQ (new address next cycle).
  - REQ with gnt same cycle, or WAIT without rvalid -> DROP.
  - WAIT with rvalid same cycle -> response discarded, -> REQ.
  - VALID -> REQ; inst_valid low next cycle.
  - IDLE -> REQ; HALT: ignored.
- DROP: counter runs; rvalid -> data discarded, -> REQ. Flush in DROP updates pc only, stays DROP.
- Timeout: counter cleared on each entry to WAIT/DROP; reaching MAX_WAIT with no rvalid -> imem_err<=1, -> HALT. HALT exits only via reset; imem_req=0, inst_valid=0.
- imem_rvalid outside WAIT/DROP is ignored. Only one request outstanding at any time.
- npc sampled only in the inst_ack cycle; pc[1:0] passed through unchanged on pc, masked only on imem_addr.

## Timing
- All outputs registered/state-decoded; no combinational path from inputs to imem_req, pc, inst, inst_valid.
- Reset exit: first clock edge with rst=1 -> IDLE to REQ; with gnt in that cycle and rvalid next, inst_valid asserts 3 edges after reset release.
- Retire-to-next-valid: inst_ack in cycle t -> imem_req at t+1 -> (gnt at t+1, rvalid at t+2) -> inst_valid at t+3. Each memory wait cycle adds one.
- rvalid is never accepted in the gnt cycle; earliest response is the cycle after gnt.
- Flush-to-request: flush in cycle t (not DROP path) -> imem_req with flush_pc at t+1.
- imem_err rises the cycle after the MAX_WAIT-th wait cycle and holds until rst=0.

## Test plan
- Reset/boot: RESET_PC=0x0, release rst, 0-wait memory returning 0x00000013 -> imem_req at cycle 1 addr 0x0, inst_valid at cycle 3 with inst=0x00000013, pc=0x0.
- Sequential fetch: npc=pc+4, inst_ack each valid cycle -> addresses 0x0,0x4,0x8 issued, valid every 3 cycles; with gnt delayed 2 cycles, valid every 5.
- Branch: in VALID at pc=0x8, npc=0x40, inst_ack -> next imem_addr=0x40, pc=0x40.
- Flush in WAIT: request 0x10 granted, flush_pc=0x100 before rvalid -> DROP; stale rvalid data 0xDEAD discarded, next request addr 0x100, inst_valid only with 0x100 data.
- Flush vs ack: flush=1, inst_ack=1 same cycle in VALID, flush_pc=0x200, npc=0x14 -> pc=0x200.
- Timeout and mid-op reset: MAX_WAIT=4, never assert rvalid -> imem_err=1, HALT, imem_req=0; assert rst=0 mid-HALT -> all outputs return to reset values immediately, fetch resumes from RESET_PC.
